// File: rtl/apb4_multislave_master.sv
// rtl/apb4_multislave_master.sv - APB4 multi-slave requester bridge
// Address-decoded PSEL, back-to-back transfers, wait-state timeout, registered response.
package apb4_multislave_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;
endpackage

module apb4_multislave_master
  import apb4_multislave_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int PROT_WIDTH = 3,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             transfer,
  input  logic                             SWRITE,
  input  logic [ADDR_WIDTH-1:0]            SADDR,
  input  logic [DATA_WIDTH-1:0]            SWDATA,
  input  logic [STRB_WIDTH-1:0]            SSTRB,
  input  logic [PROT_WIDTH-1:0]            SPROT,
  output logic                             s_ready,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [PROT_WIDTH-1:0]            PPROT,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output state_e                           cs
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SEL_W:0] NSL  = (SEL_W + 1)'(NUM_SLAVES);

  state_e                  r_state, w_next;
  logic [SEL_W-1:0]        r_sel, w_idx;
  logic [TW-1:0]           r_tcnt;
  logic                    r_derr_pend;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_WIDTH-1:0]   r_pstrb;
  logic [PROT_WIDTH-1:0]   r_pprot;
  logic                    w_pready, w_pslverr, w_timeout, w_done, w_capture, w_derr, w_derr_cap;
  logic [DATA_WIDTH-1:0]   w_prdata;

  assign w_idx  = (NUM_SLAVES > 1) ? SADDR[SEL_LSB +: SEL_W] : '0;
  assign w_derr = ({1'b0, w_idx} >= NSL);

  // Only the selected slave's response lines are ever looked at.
  always_comb begin
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_pready  = PREADY[i];
        w_pslverr = PSLVERR[i];
        w_prdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_timeout  = (TIMEOUT > 0) && (r_state == ACCESS) && !w_pready && (r_tcnt == TMAX);
  assign w_done     = (r_state == ACCESS) && (w_pready || w_timeout);
  assign s_ready    = (r_state == IDLE) || w_done;
  assign w_capture  = transfer && s_ready;
  assign w_derr_cap = w_capture && w_derr;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    PSEL    = '0;
    PENABLE = 1'b0;
    case (r_state)
      IDLE:    if (w_capture && !w_derr) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_done) w_next = (w_capture && !w_derr) ? SETUP : IDLE;
      default: w_next = IDLE;
    endcase
    if (r_state != IDLE) begin
      for (int i = 0; i < NUM_SLAVES; i++) PSEL[i] = (r_sel == SEL_W'(i));
      PENABLE = (r_state == ACCESS);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sel       <= '0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_tcnt      <= '0;
      r_derr_pend <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      if (w_capture && !w_derr) begin
        r_sel    <= w_idx;
        r_pwrite <= SWRITE;
        r_paddr  <= SADDR;
        r_pwdata <= SWDATA;
        r_pstrb  <= SWRITE ? SSTRB : '0;
        r_pprot  <= SPROT;
      end
      if (r_state == SETUP) begin
        r_tcnt <= '0;
      end else if (r_state == ACCESS && !w_pready && r_tcnt != TMAX) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      rsp_valid <= 1'b0;
      // A decode error captured on a completion edge is reported one pulse later.
      if (w_done) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= w_pready ? w_pslverr : 1'b1;
        rsp_rdata   <= (w_pready && !r_pwrite && !w_pslverr) ? w_prdata : '0;
        r_derr_pend <= w_derr_cap;
      end else if (r_derr_pend || w_derr_cap) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= 1'b1;
        rsp_rdata   <= '0;
        r_derr_pend <= r_derr_pend && w_derr_cap;
      end
    end
  end

  assign PWRITE = r_pwrite;
  assign PADDR  = r_paddr;
  assign PWDATA = r_pwdata;
  assign PSTRB  = r_pstrb;
  assign PPROT  = r_pprot;
  assign cs     = r_state;
endmodule

// File: tb/tb_apb4_multislave_master.sv
// tb/tb_apb4_multislave_master.sv - bench for apb4_multislave_master
// Two instances (4 and 3 slaves) share request and slave-side stimulus; per-instance response scoreboards.
module tb_apb4_multislave_master;
  import apb4_multislave_master_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
    logic [3:0]  exp_psel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic         PCLK, PRESETn, transfer, SWRITE;
  logic [31:0]  SADDR, SWDATA;
  logic [3:0]   SSTRB;
  logic [2:0]   SPROT;
  logic [3:0]   PREADY, PSLVERR;
  logic [127:0] PRDATA;

  logic         s_ready4, PENABLE4, PWRITE4, rsp_valid4, rsp_err4;
  logic [3:0]   PSEL4, PSTRB4;
  logic [31:0]  PADDR4, PWDATA4, rsp_rdata4;
  logic [2:0]   PPROT4;
  state_e       cs4;

  logic         s_ready3, PENABLE3, PWRITE3, rsp_valid3, rsp_err3;
  logic [2:0]   PSEL3;
  logic [3:0]   PSTRB3;
  logic [31:0]  PADDR3, PWDATA3, rsp_rdata3;
  logic [2:0]   PPROT3;
  state_e       cs3;

  int   n_checks = 0;
  int   n_pass   = 0;
  rsp_t q4[$];
  rsp_t q3[$];
  vec_t tbl[7];

  apb4_multislave_master u_dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .SWRITE(SWRITE),
    .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
    .s_ready(s_ready4), .PSEL(PSEL4), .PENABLE(PENABLE4), .PWRITE(PWRITE4),
    .PADDR(PADDR4), .PWDATA(PWDATA4), .PSTRB(PSTRB4), .PPROT(PPROT4),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .cs(cs4)
  );

  apb4_multislave_master #(.NUM_SLAVES(3)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .SWRITE(SWRITE),
    .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
    .s_ready(s_ready3), .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(PWRITE3),
    .PADDR(PADDR3), .PWDATA(PWDATA3), .PSTRB(PSTRB3), .PPROT(PPROT3),
    .PREADY(PREADY[2:0]), .PSLVERR(PSLVERR[2:0]), .PRDATA(PRDATA[95:0]),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .cs(cs3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge PCLK) begin : mon
    rsp_t e;
    if (rsp_valid4) begin
      if (q4.size() == 0) check("rsp4_unexpected", rsp_valid4, 0);
      else begin
        e = q4.pop_front();
        check("rsp4_err", rsp_err4, e.err);
        check("rsp4_rdata", rsp_rdata4, e.rdata);
      end
    end
    if (rsp_valid3) begin
      if (q3.size() == 0) check("rsp3_unexpected", rsp_valid3, 0);
      else begin
        e = q3.pop_front();
        check("rsp3_err", rsp_err3, e.err);
        check("rsp3_rdata", rsp_rdata3, e.rdata);
      end
    end
  end

  task automatic fill_prdata();
    for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = 32'hBAD0_0000 + 32'(i);
  endtask

  // Called at a negedge with both DUTs idle; returns at a negedge after completion.
  task automatic run_vec(input vec_t v);
    int         slv;
    logic       d3err;
    logic [3:0] strb_e;
    rsp_t       r;
    slv    = int'(v.addr[13:12]);
    d3err  = (slv == 3);
    strb_e = v.wr ? v.strb : 4'h0;
    transfer = 1'b1; SWRITE = v.wr; SADDR = v.addr; SWDATA = v.wdata;
    SSTRB = v.strb; SPROT = v.prot;
    PREADY  = ~(4'b0001 << slv);
    PSLVERR = ~(4'b0001 << slv);
    fill_prdata();
    PRDATA[slv*32 +: 32] = v.rdata;
    check("s_ready_idle", s_ready4, 1);
    r.err = v.exp_err; r.rdata = v.exp_rdata;
    q4.push_back(r);
    if (d3err) begin r.err = 1'b1; r.rdata = 32'h0; end
    q3.push_back(r);
    @(negedge PCLK);
    transfer = 1'b0;
    check("setup_state", cs4, SETUP);
    check("setup_psel", PSEL4, v.exp_psel);
    check("setup_penable", PENABLE4, 0);
    check("setup_paddr", PADDR4, v.addr);
    check("setup_pwrite", PWRITE4, v.wr);
    check("setup_pwdata", PWDATA4, v.wdata);
    check("setup_pstrb", PSTRB4, strb_e);
    check("setup_pprot", PPROT4, v.prot);
    check("psel3", PSEL3, d3err ? 3'b000 : v.exp_psel[2:0]);
    if (d3err) check("derr3_next_cycle", {rsp_valid3, rsp_err3}, 2'b11);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge PCLK);
      check("access_state", cs4, ACCESS);
      check("access_psel", PSEL4, v.exp_psel);
      check("access_penable", PENABLE4, 1);
      check("access_paddr", PADDR4, v.addr);
      check("access_pstrb", PSTRB4, strb_e);
      check("access_s_ready", s_ready4, 0);
      if (k == v.waits) begin
        PREADY[slv]  = 1'b1;
        PSLVERR[slv] = v.slverr;
      end
    end
    @(negedge PCLK);
    check("done_state", cs4, IDLE);
    check("done_psel", PSEL4, 0);
    check("done_penable", PENABLE4, 0);
    PREADY = 4'h0; PSLVERR = 4'h0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rsp_t r;
    int   n_acc;
    tbl[0] = '{1'b1, 32'h0000_2010, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h1111_1111, 4'b0100, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_1004, 32'h0,        4'hF, 3'd2, 3, 1'b0, 32'hA5A5_0001, 4'b0010, 1'b0, 32'hA5A5_0001};
    tbl[2] = '{1'b0, 32'h0000_0008, 32'h0,        4'h0, 3'd1, 0, 1'b1, 32'h1234_5678, 4'b0001, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 32'h0000_3000, 32'h0BAD_F00D, 4'h3, 3'd4, 2, 1'b1, 32'h0,        4'b1000, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 32'h0000_3FFC, 32'h0,        4'h0, 3'd7, 1, 1'b0, 32'hCAFE_F00D, 4'b1000, 1'b0, 32'hCAFE_F00D};
    tbl[5] = '{1'b1, 32'h0000_1ABC, 32'h1357_9BDF, 4'h5, 3'd0, 0, 1'b0, 32'h2222_2222, 4'b0010, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'hFFFF_E000, 32'h0,        4'h0, 3'd3, 1, 1'b0, 32'h5A5A_5A5A, 4'b0100, 1'b0, 32'h5A5A_5A5A};

    PRESETn = 1'b0; transfer = 1'b0; SWRITE = 1'b0; SADDR = '0; SWDATA = '0;
    SSTRB = '0; SPROT = '0; PREADY = '0; PSLVERR = '0; PRDATA = '0;
    repeat (2) @(negedge PCLK);
    check("rst_state", cs4, IDLE);
    check("rst_psel", PSEL4, 0);
    check("rst_penable", PENABLE4, 0);
    check("rst_pbus", {PWRITE4, PADDR4, PWDATA4}, 0);
    check("rst_pstrb_pprot", {PSTRB4, PPROT4}, 0);
    check("rst_rsp", {rsp_valid4, rsp_err4, rsp_rdata4}, 0);
    check("rst_rsp3", {rsp_valid3, rsp_err3, PSEL3}, 0);
    PRESETn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Back-to-back: write slave 0 then read slave 3 with transfer held high.
    transfer = 1'b1; SWRITE = 1'b1; SADDR = 32'h0000_0040; SWDATA = 32'h0102_0304;
    SSTRB = 4'hF; SPROT = 3'd0; PREADY = 4'h0; PSLVERR = 4'h0; fill_prdata();
    r.err = 1'b0; r.rdata = 32'h0;
    q4.push_back(r); q3.push_back(r);
    @(negedge PCLK);
    check("b2b_setup1", cs4, SETUP);
    check("b2b_psel1", PSEL4, 4'b0001);
    PREADY = 4'hF;
    SWRITE = 1'b0; SADDR = 32'h0000_3008; SWDATA = 32'h0;
    PRDATA[3*32 +: 32] = 32'h8765_4321;
    r.err = 1'b0; r.rdata = 32'h8765_4321; q4.push_back(r);
    r.err = 1'b1; r.rdata = 32'h0;         q3.push_back(r);
    @(negedge PCLK);
    check("b2b_access1", {cs4, PENABLE4}, {ACCESS, 1'b1});
    check("b2b_s_ready", s_ready4, 1);
    @(negedge PCLK);
    transfer = 1'b0;
    check("b2b_setup2", cs4, SETUP);
    check("b2b_psel2", PSEL4, 4'b1000);
    check("b2b_setup2_bus", {PENABLE4, PWRITE4, PADDR4, PSTRB4}, {1'b0, 1'b0, 32'h0000_3008, 4'h0});
    check("b2b_dut3_idle", {cs3, PSEL3}, {IDLE, 3'b000});
    @(negedge PCLK);
    check("b2b_access2", {cs4, PSEL4, PENABLE4}, {ACCESS, 4'b1000, 1'b1});
    @(negedge PCLK);
    check("b2b_idle", {cs4, PSEL4}, {IDLE, 4'b0000});
    PREADY = 4'h0;

    // Timeout: slave 0 never ready while the other slaves claim ready.
    transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'h0000_0100; SSTRB = 4'h0;
    PREADY = 4'b1110; PSLVERR = 4'b1110; fill_prdata();
    r.err = 1'b1; r.rdata = 32'h0;
    q4.push_back(r); q3.push_back(r);
    @(negedge PCLK);
    transfer = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (cs4 != ACCESS) break;
      n_acc++;
    end
    check("timeout_access_cycles", n_acc, 16);
    check("timeout_idle", {cs4, PSEL4, PENABLE4}, {IDLE, 4'b0000, 1'b0});
    check("timeout_idle3", cs3, IDLE);
    PREADY = 4'h0; PSLVERR = 4'h0;

    // Reset during a wait state: immediate clear, no response.
    transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'h0000_1000;
    @(negedge PCLK);
    transfer = 1'b0;
    repeat (2) @(negedge PCLK);
    check("pre_reset_access", cs4, ACCESS);
    #2 PRESETn = 1'b0;
    #1;
    check("async_rst_psel", {PSEL4, PENABLE4}, 0);
    check("async_rst_state", cs4, IDLE);
    check("async_rst_paddr", PADDR4, 0);
    check("async_rst_dut3", {PSEL3, PENABLE3}, 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("post_rst_no_rsp", {rsp_valid4, rsp_valid3}, 0);
    run_vec(tbl[1]);

    repeat (3) @(negedge PCLK);
    check("q4_drained", q4.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
